otn_frame_rec: RTL and testbench
================================

OTN_FRAME_REC -- requirements
Module: otn_frame_rec

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: `i_clk` is the single clock and `i_rst_n` is an asynchronous active-low reset.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- `i_clk` in 1: system clock.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_sclk_en_16_x_baud` in 1: one-cycle 16x-baud enable.
- `i_otn_rx_data` in 1: serial frame stream, LSB-first bytes, idle don't-care.
- `i_ack_force_bad` in 1: switch; forces a bad ACK.
- `o_otn_tx_ack` out 1: ACK line back to the sender; idle high.
- `o_frame_data` out 8: recovered payload byte.
- `o_frame_data_valid` out 1: one-cycle strobe qualifying `o_frame_data`.
- `o_frame_data_fas` out 1: one-cycle pulse on FAS lock.
- `o_frame_done` out 1: one-cycle pulse when the check verdict is known.
- `o_frame_good` out 1: verdict of the last frame; held until the next verdict.
- `o_bip_err_cnt` out 8: count of bad frames; saturates at 255.
- `o_rr_state` out 3: current state encoding.

Function
REQ-003 The block SHALL run a free-running baud counter `scount`, 0..19, that advances on `i_sclk_en_16_x_baud`.
- `sample_tick` SHALL be the enable with `scount`==9.
- `bit_tick` SHALL be the enable with `scount`==19.
REQ-004 The block SHALL pass `i_otn_rx_data` through a 2-flop synchronizer and sample it only on `sample_tick`.
REQ-005 The block SHALL use state encodings HUNT=000, RECV=001, CHECK=010, ACK_START=011, ACK_BIT=100, ACK_STOP=101; 110 and 111 SHALL go to HUNT on the next cycle.
REQ-006 HUNT:
- Each sampled bit SHALL shift into a 48-bit register, LSB-first per byte.
- On a bit-level match of the byte sequence F6 F6 F6 28 28 28, the block SHALL go to RECV, pulse `o_frame_data_fas`, and set the byte index to 6 with the bit count at 0.
REQ-007 RECV:
- Every 8 samples SHALL form one byte, with the first sampled bit as bit 0.
- The byte SHALL be presented on `o_frame_data` with `o_frame_data_valid` high for exactly one cycle, 1 clock after the `sample_tick` that completes it.
- The byte index SHALL then increment.
REQ-008 Frame length SHALL be 4164 bytes (index 0..4163).
- Indexes 6..4162 SHALL be payload and SHALL be output.
- Index 4163 SHALL be the BIP-8 byte; it SHALL NOT be output.
- After index 4163 completes, the next state SHALL be CHECK.
- Serial bits after that point SHALL be ignored until HUNT is re-entered.
REQ-009 BIP-8 SHALL be the running XOR of bytes 6..4162; it SHALL be cleared on entry to RECV.
REQ-010 CHECK SHALL last one cycle and SHALL compute good = (BIP match) AND NOT `i_ack_force_bad`, with `i_ack_force_bad` sampled in that cycle.
- `o_frame_good` SHALL be updated with good, and `o_frame_done` SHALL pulse.
- On bad, `o_bip_err_cnt` SHALL increment unless it is already 255.
- The next state SHALL be ACK_START.
REQ-011 ACK sequence, with each state lasting from one `bit_tick` to the next:
- ACK_START SHALL drive `o_otn_tx_ack`=0, waiting for the first `bit_tick`, then one full bit.
- ACK_BIT SHALL drive `o_otn_tx_ack`=good, where 1 means good.
- ACK_STOP SHALL drive `o_otn_tx_ack`=0, then return to HUNT with `o_otn_tx_ack`=1.
REQ-012 In HUNT, RECV and CHECK, `o_otn_tx_ack` SHALL be 1.
REQ-013 `o_otn_tx_ack` SHALL be registered and change only on state transitions.
REQ-014 HUNT entry SHALL clear the 48-bit shift register, so that trailing sender bits cannot cause a false lock inside the ACK window.
REQ-015 A FAS pattern appearing in RECV SHALL NOT restart the frame.
REQ-016 `sample_tick` and `bit_tick` are mutually exclusive by construction; no arbitration SHALL be needed.

Reset
REQ-017 While `i_rst_n`=0, the block SHALL be in HUNT with the following values:
- `o_otn_tx_ack`=1.
- `o_frame_data`=0, `o_frame_data_valid`=0, `o_frame_data_fas`=0, `o_frame_done`=0, `o_frame_good`=0.
- `o_bip_err_cnt`=0, `o_rr_state`=000.
- `scount`, byte index, bit count, BIP and synchronizers = 0.
REQ-018 Reset asserted mid-frame or mid-ACK SHALL abort immediately, with no further strobes, and SHALL drive the ACK line high asynchronously.

Configuration
REQ-019 Macro `OTN_RX_BIP_EN` SHALL control the BIP-8 check:
- Defined: the BIP-8 accumulator and comparison SHALL be present per REQ-009/010.
- Undefined: the accumulator SHALL be absent, good = NOT `i_ack_force_bad`, and byte 4163 SHALL still be consumed and discarded.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset, then a FAS plus 4157 payload bytes of 0x00..0xFF incrementing plus the correct BIP -> 4157 valid strobes with matching data, `o_frame_good`=1, ACK line sequence 1,0,1,0,1 with each bit 20 enables wide.
- Same frame with payload byte 100 bit 3 flipped -> `o_frame_good`=0, ACK bit=0, `o_bip_err_cnt`=1.
- FAS preceded by 5 random bits and an 0xF6 0xF6 0x28 decoy -> lock only on the true FAS and the first payload byte correct.
- Good frame with `i_ack_force_bad`=1 during CHECK -> ACK bit=0 and the counter increments.
- `i_rst_n` pulsed low at payload byte 2000 -> outputs at reset values; the next full frame is received good.
- Build without `OTN_RX_BIP_EN` and a wrong BIP byte -> `o_frame_good`=1 and ACK bit=1.

Source files
------------

// File: rtl/otn_frame_rec.sv
// -----------------------------------------------------------------------------
// otn_frame_rec -- serial OTN-style frame receiver with BIP-8 check and a
// three-bit ACK reply (start 0, verdict bit, stop 0) on an idle-high line.
//
// Ports
//   i_clk                : system clock
//   i_rst_n              : asynchronous active-low reset
//   i_sclk_en_16_x_baud  : one-cycle enable, 20 enables per serial bit
//   i_otn_rx_data        : serial frame stream, LSB-first bytes
//   i_ack_force_bad      : forces a bad verdict when sampled in CHECK
//   o_otn_tx_ack         : ACK line back to the sender, idle high
//   o_frame_data         : recovered payload byte
//   o_frame_data_valid   : one-cycle strobe qualifying o_frame_data
//   o_frame_data_fas     : one-cycle pulse on FAS lock
//   o_frame_done         : one-cycle pulse when the verdict is known
//   o_frame_good         : verdict of the last frame, held
//   o_bip_err_cnt        : saturating count of bad frames
//   o_rr_state           : current state encoding
//
// Configuration
//   OTN_RX_BIP_EN : when defined, the BIP-8 accumulator and comparison are
//                   built; otherwise the verdict depends on i_ack_force_bad
//                   only and the BIP byte is consumed and discarded.
//   FRAME_BYTES   : total frame length including FAS and BIP byte.
// -----------------------------------------------------------------------------
module otn_frame_rec #(
    parameter int FRAME_BYTES = 4164
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sclk_en_16_x_baud,
    input  logic       i_otn_rx_data,
    input  logic       i_ack_force_bad,
    output logic       o_otn_tx_ack,
    output logic [7:0] o_frame_data,
    output logic       o_frame_data_valid,
    output logic       o_frame_data_fas,
    output logic       o_frame_done,
    output logic       o_frame_good,
    output logic [7:0] o_bip_err_cnt,
    output logic [2:0] o_rr_state
);

    localparam int IDX_W = $clog2(FRAME_BYTES);
    // F6 F6 F6 28 28 28 received LSB-first: the first byte lands in bits [7:0].
    localparam logic [47:0] FAS_PATTERN = 48'h2828_28F6_F6F6;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        HUNT      = 3'b000,
        RECV      = 3'b001,
        CHECK     = 3'b010,
        ACK_START = 3'b011,
        ACK_BIT   = 3'b100,
        ACK_STOP  = 3'b101
    } state_t;

    state_t           state_r;
    logic [4:0]       scount_r;
    logic             sync1_r;
    logic             sync2_r;
    logic [46:0]      hunt_sh_r;   // previous 48-bit window without its oldest bit
    logic [6:0]       byte_sh_r;   // previous 8-bit window without its oldest bit
    logic [2:0]       bit_cnt_r;
    logic [IDX_W-1:0] byte_idx_r;
    logic             ack_arm_r;
    logic             sample_tick_s;
    logic             bit_tick_s;
    logic [47:0]      hunt_next_s;
    logic [7:0]       byte_next_s;
    logic             good_s;
`ifdef OTN_RX_BIP_EN
    logic [7:0]       bip_r;
    logic [7:0]       rx_bip_r;
`endif

    assign sample_tick_s = i_sclk_en_16_x_baud && (scount_r == 5'd9);
    assign bit_tick_s    = i_sclk_en_16_x_baud && (scount_r == 5'd19);
    assign hunt_next_s   = {sync2_r, hunt_sh_r};
    assign byte_next_s   = {sync2_r, byte_sh_r};
    assign o_rr_state    = state_r;

    // Frame verdict evaluated during CHECK.
    always_comb begin
        good_s = 1'b0;
`ifdef OTN_RX_BIP_EN
        if (bip_r == rx_bip_r) begin
            good_s = !i_ack_force_bad;
        end else begin
            good_s = 1'b0;
        end
`else
        good_s = !i_ack_force_bad;
`endif
    end

    // Free-running baud phase counter, 0..19.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scount_r <= 5'd0;
        end else if (i_sclk_en_16_x_baud) begin
            if (scount_r == 5'd19) begin
                scount_r <= 5'd0;
            end else begin
                scount_r <= scount_r + 5'd1;
            end
        end
    end

    // Two-flop synchronizer for the serial input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= i_otn_rx_data;
            sync2_r <= sync1_r;
        end
    end

    // Receiver FSM with registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r            <= HUNT;
            hunt_sh_r          <= 47'd0;
            byte_sh_r          <= 7'd0;
            bit_cnt_r          <= 3'd0;
            byte_idx_r         <= '0;
            ack_arm_r          <= 1'b0;
            o_otn_tx_ack       <= 1'b1;
            o_frame_data       <= 8'd0;
            o_frame_data_valid <= 1'b0;
            o_frame_data_fas   <= 1'b0;
            o_frame_done       <= 1'b0;
            o_frame_good       <= 1'b0;
            o_bip_err_cnt      <= 8'd0;
`ifdef OTN_RX_BIP_EN
            bip_r              <= 8'd0;
            rx_bip_r           <= 8'd0;
`endif
        end else begin
            o_frame_data_valid <= 1'b0;
            o_frame_data_fas   <= 1'b0;
            o_frame_done       <= 1'b0;
            case (state_r)
                HUNT: begin
                    if (sample_tick_s) begin
                        if (hunt_next_s == FAS_PATTERN) begin
                            state_r          <= RECV;
                            o_frame_data_fas <= 1'b1;
                            byte_idx_r       <= IDX_W'(6);
                            bit_cnt_r        <= 3'd0;
`ifdef OTN_RX_BIP_EN
                            bip_r            <= 8'd0;
`endif
                        end
                        hunt_sh_r <= hunt_next_s[47:1];
                    end
                end
                RECV: begin
                    // FAS matching is not evaluated here, so a FAS inside the payload is just data.
                    if (sample_tick_s) begin
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        byte_sh_r <= byte_next_s[7:1];
                        if (bit_cnt_r == 3'd7) begin
                            byte_idx_r <= byte_idx_r + IDX_W'(1);
                            if (byte_idx_r == LAST_IDX) begin
                                state_r <= CHECK;
`ifdef OTN_RX_BIP_EN
                                rx_bip_r <= byte_next_s;
`endif
                            end else begin
                                o_frame_data       <= byte_next_s;
                                o_frame_data_valid <= 1'b1;
`ifdef OTN_RX_BIP_EN
                                bip_r              <= bip_r ^ byte_next_s;
`endif
                            end
                        end
                    end
                end
                CHECK: begin
                    o_frame_good <= good_s;
                    o_frame_done <= 1'b1;
                    if (!good_s && (o_bip_err_cnt != 8'hFF)) begin
                        o_bip_err_cnt <= o_bip_err_cnt + 8'd1;
                    end
                    state_r      <= ACK_START;
                    o_otn_tx_ack <= 1'b0;
                    ack_arm_r    <= 1'b0;
                end
                ACK_START: begin
                    // First bit_tick only aligns to the bit grid; the second ends a full start bit.
                    if (bit_tick_s) begin
                        if (ack_arm_r) begin
                            state_r      <= ACK_BIT;
                            o_otn_tx_ack <= o_frame_good;
                        end else begin
                            ack_arm_r <= 1'b1;
                        end
                    end
                end
                ACK_BIT: begin
                    if (bit_tick_s) begin
                        state_r      <= ACK_STOP;
                        o_otn_tx_ack <= 1'b0;
                    end
                end
                ACK_STOP: begin
                    if (bit_tick_s) begin
                        state_r      <= HUNT;
                        o_otn_tx_ack <= 1'b1;
                        hunt_sh_r    <= 47'd0;   // stale sender bits must not lock
                    end
                end
                default: begin
                    state_r      <= HUNT;
                    o_otn_tx_ack <= 1'b1;
                    hunt_sh_r    <= 47'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otn_frame_rec.sv
// -----------------------------------------------------------------------------
// tb_otn_frame_rec -- directed bench for otn_frame_rec using a shortened frame
// (FRAME_BYTES = 32: FAS 0..5, payload 6..30, BIP at 31) with the baud enable
// held high, so one serial bit is 20 clocks. Expected payload, BIP, verdicts,
// counter values and ACK waveform are computed here from the frame contents.
// -----------------------------------------------------------------------------
module tb_otn_frame_rec;

    localparam int FB   = 32;
    localparam int NPAY = FB - 7;
`ifdef OTN_RX_BIP_EN
    localparam logic BIP_ON = 1'b1;
`else
    localparam logic BIP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk_en;
    logic       rx;
    logic       force_bad;
    logic       ack;
    logic [7:0] frame_data;
    logic       frame_data_valid;
    logic       frame_data_fas;
    logic       frame_done;
    logic       frame_good;
    logic [7:0] bip_err_cnt;
    logic [2:0] rr_state;

    otn_frame_rec #(.FRAME_BYTES(FB)) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_sclk_en_16_x_baud (sclk_en),
        .i_otn_rx_data       (rx),
        .i_ack_force_bad     (force_bad),
        .o_otn_tx_ack        (ack),
        .o_frame_data        (frame_data),
        .o_frame_data_valid  (frame_data_valid),
        .o_frame_data_fas    (frame_data_fas),
        .o_frame_done        (frame_done),
        .o_frame_good        (frame_good),
        .o_bip_err_cnt       (bip_err_cnt),
        .o_rr_state          (rr_state)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] fr      [0:FB-1];
    logic [7:0] exp_pay [0:NPAY-1];
    int         vidx     = 0;
    int         fas_cnt  = 0;
    int         done_cnt = 0;
    logic       last_good = 1'b0;
    int         bit_zeros;
    int         frame_zeros;
    logic       ack_last;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: payload scoreboard and pulse counters.
    always @(negedge clk) begin
        if (frame_data_valid) begin
            if (vidx < NPAY) begin
                check_val("payload", {24'd0, frame_data}, {24'd0, exp_pay[vidx]});
            end else begin
                check_val("strobe_count", vidx, NPAY - 1);
            end
            vidx++;
        end
        if (frame_data_fas) fas_cnt++;
        if (frame_done) begin
            done_cnt++;
            last_good = frame_good;
        end
    end

    // One serial bit (20 clocks); also tallies ACK-low samples.
    task automatic send_bit(input logic b);
        rx = b;
        bit_zeros = 0;
        repeat (20) begin
            @(negedge clk);
            if (!ack) bit_zeros++;
        end
        ack_last = ack;
        frame_zeros += bit_zeros;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic build_frame(input logic [7:0] base, input int flip_idx, input logic bad_bip);
        logic [7:0] bip;
        bip = 8'd0;
        fr[0] = 8'hF6; fr[1] = 8'hF6; fr[2] = 8'hF6;
        fr[3] = 8'h28; fr[4] = 8'h28; fr[5] = 8'h28;
        for (int k = 0; k < NPAY; k++) begin
            fr[6 + k]  = base + 8'(k);
            bip        = bip ^ fr[6 + k];
            exp_pay[k] = fr[6 + k];
        end
        if (flip_idx >= 0) begin
            fr[6 + flip_idx]  = fr[6 + flip_idx] ^ 8'h08;
            exp_pay[flip_idx] = fr[6 + flip_idx];
        end
        fr[FB - 1] = bad_bip ? (bip ^ 8'h5A) : bip;
    endtask

    // Send the built frame, then check verdict and the ACK waveform bit by bit.
    task automatic run_frame(input string tag, input logic exp_good, input int exp_err, input logic force_last);
        int fas0;
        int done0;
        vidx = 0;
        fas0 = fas_cnt;
        done0 = done_cnt;
        frame_zeros = 0;
        for (int i = 0; i < FB; i++) begin
            if (i == FB - 1 && force_last) force_bad = 1'b1;
            if (i == 8) check_val({tag, "/state_recv"}, {29'd0, rr_state}, 32'd1);
            send_byte(fr[i]);
        end
        check_val({tag, "/fas_pulses"}, fas_cnt - fas0, 32'd1);
        check_val({tag, "/strobes"}, vidx, NPAY);
        check_val({tag, "/done_pulses"}, done_cnt - done0, 32'd1);
        check_val({tag, "/good_at_done"}, {31'd0, last_good}, {31'd0, exp_good});
        check_val({tag, "/frame_good"}, {31'd0, frame_good}, {31'd0, exp_good});
        check_val({tag, "/err_cnt"}, {24'd0, bip_err_cnt}, exp_err);
        // ACK drops 1 clock after the last sample: 10 low samples in the last bit.
        check_val({tag, "/ack_low_last_bit"}, frame_zeros, 32'd10);
        send_bit(1'b1);
        force_bad = 1'b0;
        check_val({tag, "/start_low"}, bit_zeros, exp_good ? 32'd19 : 32'd20);
        check_val({tag, "/ack_bit_edge"}, {31'd0, ack_last}, {31'd0, exp_good});
        check_val({tag, "/state_ackbit"}, {29'd0, rr_state}, 32'd4);
        send_bit(1'b1);
        check_val({tag, "/ack_bit_low"}, bit_zeros, exp_good ? 32'd1 : 32'd20);
        check_val({tag, "/stop_edge"}, {31'd0, ack_last}, 32'd0);
        check_val({tag, "/state_ackstop"}, {29'd0, rr_state}, 32'd5);
        send_bit(1'b1);
        check_val({tag, "/stop_low"}, bit_zeros, 32'd19);
        check_val({tag, "/idle_edge"}, {31'd0, ack_last}, 32'd1);
        check_val({tag, "/state_hunt"}, {29'd0, rr_state}, 32'd0);
        send_bit(1'b1);
        check_val({tag, "/idle_low"}, bit_zeros, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "/ack"}, {31'd0, ack}, 32'd1);
        check_val({tag, "/data"}, {24'd0, frame_data}, 32'd0);
        check_val({tag, "/valid"}, {31'd0, frame_data_valid}, 32'd0);
        check_val({tag, "/fas"}, {31'd0, frame_data_fas}, 32'd0);
        check_val({tag, "/done"}, {31'd0, frame_done}, 32'd0);
        check_val({tag, "/good"}, {31'd0, frame_good}, 32'd0);
        check_val({tag, "/err_cnt"}, {24'd0, bip_err_cnt}, 32'd0);
        check_val({tag, "/state"}, {29'd0, rr_state}, 32'd0);
    endtask

    initial begin
        int v0;
        logic [7:0] decoy [0:2];
        rst_n = 1'b0;
        sclk_en = 1'b1;
        rx = 1'b1;
        force_bad = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (3) send_bit(1'b1);

        // Good frame, payload wraps through 0xFF.
        build_frame(8'hF0, -1, 1'b0);
        run_frame("good", 1'b1, 0, 1'b0);

        // Good frame but verdict forced bad in CHECK.
        build_frame(8'h10, -1, 1'b0);
        run_frame("force_bad", 1'b0, 1, 1'b1);

        // Payload byte 10 bit 3 flipped, BIP from the original payload.
        build_frame(8'h00, 10, 1'b0);
        run_frame("flip", !BIP_ON, 1 + int'(BIP_ON), 1'b0);

        // Random bits and an F6 F6 28 decoy ahead of the true FAS.
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(1, 0)));
        decoy[0] = 8'hF6; decoy[1] = 8'hF6; decoy[2] = 8'h28;
        for (int i = 0; i < 3; i++) send_byte(decoy[i]);
        build_frame(8'h5C, -1, 1'b0);
        run_frame("decoy", 1'b1, 1 + int'(BIP_ON), 1'b0);

        // Reset in the middle of payload byte 15, then a clean frame.
        build_frame(8'h33, -1, 1'b0);
        vidx = 0;
        for (int i = 0; i < 6 + 15; i++) send_byte(fr[i]);
        for (int i = 0; i < 3; i++) send_bit(fr[21][i]);
        check_val("midframe/strobes", vidx, 32'd15);
        #3 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        v0 = vidx;
        repeat (4) @(negedge clk);
        check_val("midreset/no_strobe", vidx, v0);
        rst_n = 1'b1;
        repeat (3) send_bit(1'b1);
        build_frame(8'hA7, -1, 1'b0);
        run_frame("after_reset", 1'b1, 0, 1'b0);

        // Wrong BIP byte: only detected when the check is built in.
        build_frame(8'h80, -1, 1'b1);
        run_frame("bad_bip", !BIP_ON, int'(BIP_ON), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
